// File: rtl/dr_pkg.sv
// dr_pkg: shared encoding, rail index and receiver FSM types for the dual-rail receiver
package dr_pkg;
  typedef enum logic {ENC_TP, ENC_FP} enc_t;
  typedef enum logic [1:0] {IDLE, CHECK, RTZ} rx_state_t;
  localparam int RAIL_NUM = 2;
  localparam int RAIL_T = 1;
  localparam int RAIL_F = 0;
endpackage

// File: rtl/dr_sync.sv
// dr_sync: two-flop synchroniser array with asynchronous clear
module dr_sync #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/dr_sync_receiver.sv
// dr_sync_receiver: synchronises dual-rail tokens, detects completion and returns the producer acknowledge
module dr_sync_receiver
  import dr_pkg::*;
#(
  parameter enc_t ENC   = ENC_TP,
  parameter int   WIDTH = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0]   dr_in,
  output logic                             ack,
  output logic [WIDTH-1:0]                 data_out,
  output logic                             valid,
  input  logic                             ready,
  output logic                             err
);
  logic [WIDTH-1:0][RAIL_NUM-1:0] sync_in, lvl, snap_q, snap_d, ref_q, ref_d;
  logic [WIDTH-1:0] word, one_hot, bad, data_q, data_d;
  logic complete, illegal, cap;
  logic ack_q, ack_d, valid_q, valid_d, err_q, err_d;
  rx_state_t state_q, state_d;

  dr_sync #(.N(WIDTH * RAIL_NUM)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (dr_in),
    .q    (sync_in)
  );

  // Two-phase compares against the last accepted levels; four-phase reads levels directly.
  assign lvl = (ENC == ENC_FP) ? sync_in : sync_in ^ ref_q;

  always_comb begin
    word    = '0;
    one_hot = '0;
    bad     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word[i]    = lvl[i][RAIL_T];
      one_hot[i] = lvl[i][RAIL_T] ^ lvl[i][RAIL_F];
      bad[i]     = lvl[i][RAIL_T] & lvl[i][RAIL_F];
    end
  end

  assign complete = &one_hot;
  assign illegal  = |bad;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ref_d   = ref_q;
    ack_d   = ack_q;
    data_d  = data_q;
    err_d   = illegal;
    cap     = 1'b0;
    case (state_q)
      IDLE: if (en && complete) begin
        snap_d  = sync_in;
        state_d = CHECK;
      end
      CHECK: if (sync_in != snap_q || !complete) begin
        state_d = IDLE;
      end else if (!valid_q || ready) begin
        cap     = 1'b1;
        data_d  = word;
        ack_d   = (ENC == ENC_FP) ? 1'b1 : !ack_q;
        state_d = (ENC == ENC_FP) ? RTZ : IDLE;
        ref_d   = (ENC == ENC_FP) ? ref_q : snap_q;
      end
      RTZ: if (sync_in == '0) begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = cap | (valid_q & ~ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      ref_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ref_q   <= ref_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ack      = ack_q;
  assign data_out = data_q;
  assign valid    = valid_q;
  assign err      = err_q;
endmodule

// File: doc/dr_sync_receiver.md
# dr_sync_receiver

Clocked receiver closing a dual-rail self-timed datapath (adders, full-adder chains) into the synchronous domain. It synchronises WIDTH dual-rail bit pairs and detects completion under the configured encoding. It captures the decoded word into a valid/ready output register and returns the acknowledge that lets the async producer issue its next token. It sits at the async→sync boundary, after the last dual-rail arithmetic stage.

## Interface
- ENC, "TP": dual-rail encoding; "TP" two-phase (transition) or "FP" four-phase return-to-zero.
- WIDTH, 1: number of dual-rail bits received.
- RAIL_NUM, 2 (localparam): rails per bit; rail[1] = true, rail[0] = false.

Ports:
- clk  in  1  receiver clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  enable; low blocks new captures from IDLE.
- dr_in  in  [WIDTH-1:0][RAIL_NUM-1:0]  dual-rail data from async producer (unclocked).
- ack  out  1  acknowledge to producer; FP level 0/1, TP toggles once per token.
- data_out  out  WIDTH  decoded word.
- valid  out  1  data_out holds an unconsumed word.
- ready  in  1  consumer accepts data_out when valid && ready.
- err  out  1  one-cycle pulse on illegal rail code.

## Operation
- All rails pass through a 2-flop synchroniser; sync_in is the synchronised copy. Logic uses only sync_in.
- FP decode: 10 = 1, 01 = 0, 00 = spacer, 11 = illegal. Complete = every pair exactly one rail high.
- TP decode: ref holds the last accepted rail levels (reset 0). A bit is 1 if only rail[1] differs from ref and 0 if only rail[0] differs. Complete = every pair has exactly one differing rail. Both rails differing is illegal.
- FSM states IDLE, CHECK, RTZ:
  - IDLE: if en && complete, snapshot sync_in and go to CHECK.
  - CHECK: if sync_in ≠ snapshot or the word is not complete, go to IDLE (skew filter). Otherwise wait for a free slot, meaning !valid || ready. When the slot is free: load data_out, set valid, and raise ack (FP) or toggle ack (TP). The next state is RTZ for FP. For TP, set ref ← snapshot and go to IDLE.
  - RTZ (FP only): wait for every pair of sync_in to be 00, then drop ack and go to IDLE.
- valid clears on valid && ready unless a capture happens in the same cycle, in which case it stays 1 with the new data.
- err pulses for one cycle whenever sync_in holds any illegal pair. State is unaffected; an illegal word never counts as complete.
- en low: IDLE holds. CHECK and RTZ run to completion so the handshake is never abandoned.

## Timing
- Reset values: ack=0, data_out=0, valid=0, err=0, ref=0, state=IDLE, synchroniser flops 0.
- Latency: inputs settle before edge N. sync_in is valid at N+2, CHECK is entered at N+3, and valid/ack/data_out are registered at N+4. This is the minimum of 4 cycles with a free slot.
- Back-pressure: while valid && !ready, CHECK holds and ack is withheld. The producer therefore stalls with no token loss.
- FP cycle: ack falls 3 cycles after the spacer settles (2 for the synchroniser, 1 for RTZ).
- Reset mid-handshake: all state clears immediately and ack goes to 0. The producer must be reset together with the receiver.
- Single-rail glitches shorter than two clocks may be captured by the synchroniser. The CHECK stability compare rejects any word not held for two consecutive sync samples.

## Structure
- Package dr_pkg:
  - enc_t enum (ENC_TP, ENC_FP)
  - rail index constants RAIL_T=1, RAIL_F=0
  - FSM state typedef rx_state_t {IDLE, CHECK, RTZ}
  - RAIL_NUM constant
- Sub-module dr_sync: parameterised 2-flop synchroniser array (rst_n async clear), instantiated once over all WIDTH×RAIL_NUM rails.

## Test plan
- FP, WIDTH=4, ready=1: drive 10,01,10,10 (word 4'b1011); then valid=1 with data_out=4'hB and ack=1 at edge N+4. Drive spacer; then ack=0 3 cycles after the spacer settles.
- TP, WIDTH=4, from ref=0: toggle rail[1] of bits 0,2 and rail[0] of bits 1,3 → data_out=4'h5 and ack toggles to 1. Next toggle rail[1] on all bits → data_out=4'hF and ack toggles to 0.
- Back-pressure, FP: ready=0 with valid=1 and a second complete word applied → ack stays 0 from RTZ-exit and no capture occurs. Raise ready → new word is captured 1 cycle later with valid continuously 1.
- Skew: FP bits arrive staggered by 1 cycle each → no capture until all 4 are stable for 2 sync samples, then a single correct capture and exactly one ack.
- Illegal code: FP bit 2 = 11 for 3 cycles → err high for 3 cycles, no valid, state IDLE. Then fix the bit to 10 → normal capture.
- Reset mid-RTZ: assert rst_n=0 while ack=1 → ack, valid, data_out go to 0 asynchronously. After release the FSM is in IDLE and ref=0.
